qam16_rx_demod: RTL and testbench

- Receive-side counterpart of the QAM16 transmit chain. Takes the matched-filtered I/Q sample streams (16-bit signed, SPS samples per symbol, filter output rate) and discards the filter group-delay transient.
- Decimates to one sample per symbol at a fixed timing phase, slices each axis to one of four levels, and demaps to the 4-bit symbol the transmit PRBS generated.
- Sits after the receive-side RRC filter pair. Feeds a downstream PRBS checker.

---
 rtl/qam16_rx_demod.sv | 113 +++++++++++
 tb/tb_qam16_rx_demod.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/qam16_rx_demod.sv
// QAM16 receive demodulator: discards the matched-filter start-up transient, decimates
// to one sample per symbol at a fixed phase, slices both axes and Gray-demaps to 4 bits.
module qam16_rx_demod #(
  parameter int SPS       = 4,
  parameter int PHASE     = 0,
  parameter int FLUSH_LEN = 10,
  parameter int THR       = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din_i,
  input  logic [15:0] din_q,
  input  logic        din_valid,
  output logic [3:0]  data_out,
  output logic        data_valid,
  output logic        locked,
  output logic [15:0] sym_cnt
);

  localparam int FW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);
  localparam logic signed [15:0] thr_pos = 16'(THR);
  localparam logic signed [15:0] thr_neg = -thr_pos;

  typedef enum logic {FLUSH, RUN} state_t;

  state_t          state_reg, state_next;
  logic [FW-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [3:0]      phase_reg, phase_next;
  logic            take;
  logic [3:0]      sym_bits;
  logic [15:0]     axis [2];

  logic [3:0]      data_out_reg;
  logic            data_valid_reg;
  logic            locked_reg;
  logic [15:0]     sym_cnt_reg;

  assign axis[0] = din_q;
  assign axis[1] = din_i;

  // Slice each axis to one of four levels, emitting the Gray code directly.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slicer
      logic signed [15:0] x;
      assign x = axis[gi];
      assign sym_bits[2*gi +: 2] = (x >= thr_pos)  ? 2'b10 :
                                   (x >= 16'sd0)   ? 2'b11 :
                                   (x >= thr_neg)  ? 2'b01 : 2'b00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= (FLUSH_LEN == 0) ? RUN : FLUSH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    phase_next     = phase_reg;
    take           = 1'b0;
    case (state_reg)
      FLUSH: begin
        if (din_valid) begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
          if (flush_cnt_next == FW'(FLUSH_LEN)) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (din_valid) begin
          take       = (phase_reg == 4'(PHASE));
          phase_next = (phase_reg == 4'(SPS - 1)) ? 4'd0 : phase_reg + 4'd1;
        end
      end
      default: state_next = FLUSH;
    endcase
  end

  // locked follows the next state so it rises the cycle after the last discarded sample,
  // yet stays low through the cycle following reset even when no flush is configured.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_reg  <= '0;
      phase_reg      <= 4'd0;
      data_out_reg   <= 4'd0;
      data_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      sym_cnt_reg    <= 16'd0;
    end else begin
      flush_cnt_reg  <= flush_cnt_next;
      phase_reg      <= phase_next;
      data_valid_reg <= take;
      locked_reg     <= (state_next == RUN);
      if (take) begin
        data_out_reg <= sym_bits;
        if (sym_cnt_reg != 16'hFFFF) begin
          sym_cnt_reg <= sym_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign locked     = locked_reg;
  assign sym_cnt    = sym_cnt_reg;

endmodule

// File: tb/tb_qam16_rx_demod.sv
// Directed bench for qam16_rx_demod: flush/lock timing, constellation and threshold
// slicing, PHASE=2 decimation with gapped valid, mid-run reset and a PRBS loopback.
module tb_qam16_rx_demod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, valid_a, dv_a, locked_a;
  logic [15:0] i_a, q_a, cnt_a;
  logic [3:0]  data_a;

  logic        reset_b, valid_b, dv_b, locked_b;
  logic [15:0] i_b, q_b, cnt_b;
  logic [3:0]  data_b;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [6:0] lfsr;

  qam16_rx_demod dut_a (
    .clk(clk), .reset(reset_a), .din_i(i_a), .din_q(q_a), .din_valid(valid_a),
    .data_out(data_a), .data_valid(dv_a), .locked(locked_a), .sym_cnt(cnt_a)
  );

  qam16_rx_demod #(.PHASE(2)) dut_b (
    .clk(clk), .reset(reset_b), .din_i(i_b), .din_q(q_b), .din_valid(valid_b),
    .data_out(data_b), .data_valid(dv_b), .locked(locked_b), .sym_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_a(input logic [15:0] val);
    for (int k = 1; k <= 10; k++) begin
      valid_a = 1'b1; i_a = val; q_a = val;
      step();
      chk("a_flush_dv", dv_a, 1'b0);
      chk("a_flush_locked", locked_a, (k == 10) ? 1'b1 : 1'b0);
    end
  endtask

  // One symbol on DUT A (PHASE=0); with hold=0 the other phases carry decoy values.
  task automatic sym_a(input logic [15:0] i, input logic [15:0] q, input logic [3:0] exp,
                       input bit hold, input string tag);
    for (int k = 0; k < 4; k++) begin
      valid_a = 1'b1;
      i_a = (k == 0 || hold) ? i : 16'h8000;
      q_a = (k == 0 || hold) ? q : 16'h7FFF;
      step();
      if (k == 0) begin
        exp_cnt++;
        chk({tag, "_dv"}, dv_a, 1'b1);
        chk({tag, "_data"}, data_a, exp);
        chk({tag, "_cnt"}, cnt_a, exp_cnt);
        if (!hold)
          $display("[TB] %s i=%0d q=%0d data=%b cnt=%0d", tag, $signed(i), $signed(q), data_a, cnt_a);
      end else begin
        chk({tag, "_nodv"}, dv_a, 1'b0);
      end
    end
  endtask

  // One symbol on DUT B (PHASE=2), every valid sample followed by an idle cycle.
  task automatic sym_b(input logic [15:0] i, input logic [15:0] q, input logic [3:0] exp);
    logic signed [15:0] decoy_i [4];
    decoy_i = '{-16'sd6000, -16'sd1000, 16'sd0, 16'sd6000};
    for (int ph = 0; ph < 4; ph++) begin
      valid_b = 1'b1;
      i_b = (ph == 2) ? i : decoy_i[ph];
      q_b = (ph == 2) ? q : decoy_i[ph];
      step();
      chk("b_dv_valid_cycle", dv_b, (ph == 2) ? 1'b1 : 1'b0);
      if (ph == 2) begin
        exp_cnt++;
        chk("b_data", data_b, exp);
        chk("b_cnt", cnt_b, exp_cnt);
        $display("[TB] b_sym i=%0d q=%0d data=%b cnt=%0d", $signed(i), $signed(q), data_b, cnt_b);
      end
      valid_b = 1'b0;
      i_b = 16'h8000; q_b = 16'h8000;
      step();
      chk("b_dv_idle_cycle", dv_b, 1'b0);
    end
  endtask

  function automatic logic [15:0] level(input logic [1:0] code);
    case (code)
      2'b00:   return -16'sd6000;
      2'b01:   return -16'sd1000;
      2'b11:   return 16'sd1000;
      default: return 16'sd6000;
    endcase
  endfunction

  function automatic logic [3:0] prbs_nibble();
    logic [3:0] n;
    for (int b = 0; b < 4; b++) begin
      n    = {n[2:0], lfsr[6] ^ lfsr[5]};
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
    return n;
  endfunction

  initial begin
    logic signed [15:0] lv [4];
    logic [1:0]         gc [4];
    logic signed [15:0] thr_i [5];
    logic [3:0]         thr_exp [5];
    logic [3:0]         s;

    lv      = '{-16'sd6000, -16'sd1000, 16'sd1000, 16'sd6000};
    gc      = '{2'b00, 2'b01, 2'b11, 2'b10};
    thr_i   = '{16'sd2048, 16'sd2047, -16'sd2048, -16'sd2049, -16'sd32768};
    thr_exp = '{4'b1011, 4'b1111, 4'b0111, 4'b0011, 4'b0011};

    reset_a = 1'b1; valid_a = 1'b1; i_a = 16'd6000; q_a = 16'd6000;
    reset_b = 1'b1; valid_b = 1'b0; i_b = 16'd0; q_b = 16'd0;
    step();
    step();
    chk("rst_data", data_a, 4'd0);
    chk("rst_dv", dv_a, 1'b0);
    chk("rst_locked", locked_a, 1'b0);
    chk("rst_cnt", cnt_a, 16'd0);
    reset_a = 1'b0;

    // Default flush and the first all-zero symbols
    flush_a(16'd0);
    for (int n = 0; n < 3; n++) sym_a(16'd0, 16'd0, 4'b1111, 1'b1, "zero");

    // Constellation sweep
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        sym_a(lv[a], lv[b], {gc[a], gc[b]}, 1'b0, "sweep");

    // Threshold boundaries on I
    for (int n = 0; n < 5; n++) sym_a(thr_i[n], 16'd0, thr_exp[n], 1'b0, "thr");

    // Reset on a decision cycle: no strobe, full re-flush needed
    reset_a = 1'b1; valid_a = 1'b1; i_a = 16'd6000; q_a = 16'd6000;
    step();
    chk("midrst_dv", dv_a, 1'b0);
    chk("midrst_locked", locked_a, 1'b0);
    chk("midrst_cnt", cnt_a, 16'd0);
    chk("midrst_data", data_a, 4'd0);
    reset_a = 1'b0;
    exp_cnt = 0;
    flush_a(16'd6000);
    sym_a(16'd6000, -16'sd1000, 4'b1001, 1'b0, "post_rst");

    // PRBS loopback, 1000 symbols
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    exp_cnt = 0;
    flush_a(16'd0);
    lfsr = 7'h5A;
    for (int n = 0; n < 1000; n++) begin
      s = prbs_nibble();
      sym_a(level(s[3:2]), level(s[1:0]), s, 1'b1, "loop");
    end
    chk("loop_cnt", cnt_a, 16'd1000);
    $display("[TB] loopback done, sym_cnt=%0d", cnt_a);

    // DUT B: PHASE=2 with din_valid toggling
    valid_a = 1'b0;
    step();
    chk("b_rst_locked", locked_b, 1'b0);
    chk("b_rst_cnt", cnt_b, 16'd0);
    reset_b = 1'b0;
    exp_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      valid_b = 1'b1; i_b = 16'd6000; q_b = 16'd6000;
      step();
      chk("b_flush_dv", dv_b, 1'b0);
      chk("b_flush_locked", locked_b, (k == 10) ? 1'b1 : 1'b0);
      valid_b = 1'b0;
      step();
      chk("b_flush_idle_dv", dv_b, 1'b0);
      chk("b_flush_idle_locked", locked_b, (k == 10) ? 1'b1 : 1'b0);
    end
    sym_b(16'sd1000, -16'sd6000, 4'b1100);
    sym_b(16'sd6000, -16'sd1000, 4'b1001);
    sym_b(-16'sd6000, 16'sd6000, 4'b0010);
    sym_b(-16'sd1000, 16'sd1000, 4'b0111);
    chk("b_final_data_hold", data_b, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
